// File: rtl/vgachargen_pkg.sv
// Shared types and constants for the vgachargen APB front-end: window map,
// transfer FSM states and the setup-phase error decoder.
package vgachargen_pkg;

  localparam logic [1:0] WIN_CH_MAP  = 2'd0;
  localparam logic [1:0] WIN_COL_MAP = 2'd1;
  localparam logic [1:0] WIN_TIFF    = 2'd2;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} apb_state_e;

  // Returns 1 when the access must be answered with pslverr instead of touching memory.
  function automatic logic apb_decode_err(input logic [13:0] paddr,
                                          input logic        pwrite,
                                          input logic [3:0]  pstrb,
                                          input int          ch_words,
                                          input int          col_words,
                                          input int          tiff_words);
    int   idx;
    logic err;
    idx = int'(paddr[11:2]);
    err = (paddr[1:0] != 2'b00);
    case (paddr[13:12])
      WIN_CH_MAP:  err = err | (idx >= ch_words);
      WIN_COL_MAP: err = err | (idx >= col_words);
      WIN_TIFF:    err = err | (idx >= tiff_words) | (pwrite & (pstrb != 4'hF));
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/apb_vgachargen_ctrl.sv
// APB3 slave bridging single transfers onto vgachargen's char_map, col_map and
// char_tiff memory ports; one wait state per good transfer, zero for errors.
module apb_vgachargen_ctrl
  import vgachargen_pkg::*;
#(
  parameter int APB_ADDR_W    = 14,
  parameter int CH_MAP_WORDS  = 600,
  parameter int COL_MAP_WORDS = 600,
  parameter int TIFF_WORDS    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [MEM_ADDR_W-1:0] char_map_addr_o,
  output logic                  char_map_we_o,
  output logic [3:0]            char_map_be_o,
  output logic [MEM_DATA_W-1:0] char_map_wdata_o,
  input  logic [MEM_DATA_W-1:0] char_map_rdata_i,
  output logic [MEM_ADDR_W-1:0] col_map_addr_o,
  output logic                  col_map_we_o,
  output logic [3:0]            col_map_be_o,
  output logic [MEM_DATA_W-1:0] col_map_wdata_o,
  input  logic [MEM_DATA_W-1:0] col_map_rdata_i,
  output logic [MEM_ADDR_W-1:0] char_tiff_addr_o,
  output logic                  char_tiff_we_o,
  output logic [MEM_DATA_W-1:0] char_tiff_wdata_o,
  input  logic [MEM_DATA_W-1:0] char_tiff_rdata_i
);

  apb_state_e            state;
  logic [1:0]            cap_win;
  logic                  cap_write;
  logic                  cap_err;
  logic [1:0]            win;
  logic [MEM_ADDR_W-1:0] word_idx;
  logic                  err_setup;

  assign win       = paddr_i[13:12];
  assign word_idx  = paddr_i[11:2];
  assign err_setup = apb_decode_err(paddr_i[13:0], pwrite_i, pstrb_i,
                                    CH_MAP_WORDS, COL_MAP_WORDS, TIFF_WORDS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      cap_win           <= '0;
      cap_write         <= 1'b0;
      cap_err           <= 1'b0;
      pready_o          <= 1'b0;
      pslverr_o         <= 1'b0;
      char_map_addr_o   <= '0;
      char_map_we_o     <= 1'b0;
      char_map_be_o     <= '0;
      char_map_wdata_o  <= '0;
      col_map_addr_o    <= '0;
      col_map_we_o      <= 1'b0;
      col_map_be_o      <= '0;
      col_map_wdata_o   <= '0;
      char_tiff_addr_o  <= '0;
      char_tiff_we_o    <= 1'b0;
      char_tiff_wdata_o <= '0;
    end else begin
      // Strobes and handshake are single-cycle pulses unless set below.
      char_map_we_o  <= 1'b0;
      col_map_we_o   <= 1'b0;
      char_tiff_we_o <= 1'b0;
      pready_o       <= 1'b0;
      pslverr_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (psel_i && !penable_i) begin
            state     <= ACCESS;
            cap_win   <= win;
            cap_write <= pwrite_i;
            cap_err   <= err_setup;
            if (err_setup) begin
              pready_o  <= 1'b1;
              pslverr_o <= 1'b1;
            end else begin
              case (win)
                WIN_CH_MAP: begin
                  char_map_addr_o  <= word_idx;
                  char_map_be_o    <= pstrb_i;
                  char_map_wdata_o <= pwdata_i;
                  char_map_we_o    <= pwrite_i;
                end
                WIN_COL_MAP: begin
                  col_map_addr_o  <= word_idx;
                  col_map_be_o    <= pstrb_i;
                  col_map_wdata_o <= pwdata_i;
                  col_map_we_o    <= pwrite_i;
                end
                WIN_TIFF: begin
                  char_tiff_addr_o  <= word_idx;
                  char_tiff_wdata_o <= pwdata_i;
                  char_tiff_we_o    <= pwrite_i;
                end
                default: ;
              endcase
            end
          end
        end
        ACCESS: begin
          if (!psel_i || cap_err) begin
            state <= IDLE;
          end else begin
            state    <= RESP;
            pready_o <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory read data arrives the cycle after ACCESS, so it is muxed straight out in RESP.
  always_comb begin
    prdata_o = '0;
    if (state == RESP && !cap_write) begin
      case (cap_win)
        WIN_CH_MAP:  prdata_o = char_map_rdata_i;
        WIN_COL_MAP: prdata_o = col_map_rdata_i;
        WIN_TIFF:    prdata_o = char_tiff_rdata_i;
        default:     prdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_vgachargen_ctrl.sv
// Directed bench for apb_vgachargen_ctrl with behavioural synchronous memories.
module tb_apb_vgachargen_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [13:0] paddr_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] pwdata_i;
  logic [3:0]  pstrb_i;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [9:0]  char_map_addr_o, col_map_addr_o, char_tiff_addr_o;
  logic        char_map_we_o, col_map_we_o, char_tiff_we_o;
  logic [3:0]  char_map_be_o, col_map_be_o;
  logic [31:0] char_map_wdata_o, col_map_wdata_o, char_tiff_wdata_o;
  logic [31:0] char_map_rdata_i, col_map_rdata_i, char_tiff_rdata_i;

  bit [31:0] ch_mem   [1024];
  bit [31:0] col_mem  [1024];
  bit [31:0] tiff_mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  apb_vgachargen_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .psel_i(psel_i),
    .penable_i(penable_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .char_map_addr_o(char_map_addr_o), .char_map_we_o(char_map_we_o),
    .char_map_be_o(char_map_be_o), .char_map_wdata_o(char_map_wdata_o),
    .char_map_rdata_i(char_map_rdata_i),
    .col_map_addr_o(col_map_addr_o), .col_map_we_o(col_map_we_o),
    .col_map_be_o(col_map_be_o), .col_map_wdata_o(col_map_wdata_o),
    .col_map_rdata_i(col_map_rdata_i),
    .char_tiff_addr_o(char_tiff_addr_o), .char_tiff_we_o(char_tiff_we_o),
    .char_tiff_wdata_o(char_tiff_wdata_o), .char_tiff_rdata_i(char_tiff_rdata_i)
  );

  function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] d, input logic [3:0] be);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (char_map_we_o) ch_mem[char_map_addr_o] <= merge(ch_mem[char_map_addr_o], char_map_wdata_o, char_map_be_o);
    if (col_map_we_o) col_mem[col_map_addr_o] <= merge(col_mem[col_map_addr_o], col_map_wdata_o, col_map_be_o);
    if (char_tiff_we_o) tiff_mem[char_tiff_addr_o] <= char_tiff_wdata_o;
    char_map_rdata_i  <= ch_mem[char_map_addr_o];
    col_map_rdata_i   <= col_mem[col_map_addr_o];
    char_tiff_rdata_i <= tiff_mem[char_tiff_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer; reports read data, slverr, wait cycles before pready and we pulses seen.
  task automatic xfer(input logic [13:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic err, output int waits, output int we_cnt);
    bit done;
    done = 0; waits = 0; we_cnt = 0; rd = '0; err = 1'b0;
    @(posedge clk_i); #1;
    paddr_i = a; pwrite_i = w; pwdata_i = d; pstrb_i = s; psel_i = 1'b1; penable_i = 1'b0;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    for (int i = 0; i < 6 && !done; i++) begin
      @(negedge clk_i);
      if (int'(char_map_we_o) + int'(col_map_we_o) + int'(char_tiff_we_o) > 1)
        chk("we_onehot", 32'(int'(char_map_we_o) + int'(col_map_we_o) + int'(char_tiff_we_o)), 32'd1);
      we_cnt += int'(char_map_we_o) + int'(col_map_we_o) + int'(char_tiff_we_o);
      if (pready_o) begin
        rd = prdata_o; err = pslverr_o; done = 1;
      end else begin
        waits++;
      end
      @(posedge clk_i); #1;
    end
    psel_i = 1'b0; penable_i = 1'b0;
    if (!done) chk("pready_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits, wec;

  task automatic good(input string tag, input logic [13:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd);
    xfer(a, w, d, s, rd, err, waits, wec);
    chk({tag, "_slverr"}, 32'(err), 32'd0);
    chk({tag, "_waits"}, 32'(waits), 32'd1);
    chk({tag, "_we"}, 32'(wec), w ? 32'd1 : 32'd0);
    chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  task automatic bad(input string tag, input logic [13:0] a, input logic w, input logic [3:0] s);
    xfer(a, w, 32'h1234_5678, s, rd, err, waits, wec);
    chk({tag, "_slverr"}, 32'(err), 32'd1);
    chk({tag, "_waits"}, 32'(waits), 32'd0);
    chk({tag, "_we"}, 32'(wec), 32'd0);
    chk({tag, "_rdata"}, rd, 32'd0);
  endtask

  function automatic logic [31:0] sweep_val(input int win, input int i);
    return (32'(win) << 28) | (32'(i) * 32'h0001_0003);
  endfunction

  initial begin
    rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_pready", 32'(pready_o), 32'd0);
    chk("rst_pslverr", 32'(pslverr_o), 32'd0);
    chk("rst_prdata", prdata_o, 32'd0);
    chk("rst_we", {29'd0, char_map_we_o, col_map_we_o, char_tiff_we_o}, 32'd0);
    chk("rst_addr", {2'd0, char_map_addr_o, col_map_addr_o, char_tiff_addr_o}, 32'd0);
    @(negedge clk_i); rst_i = 1'b0;

    // Reset in the middle of a char_map write kills the strobe immediately.
    @(posedge clk_i); #1;
    paddr_i = 14'h000C; pwrite_i = 1'b1; pwdata_i = 32'hCAFE_F00D; pstrb_i = 4'hF;
    psel_i = 1'b1; penable_i = 1'b0;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    chk("mid_we_high", 32'(char_map_we_o), 32'd1);
    chk("mid_addr", 32'(char_map_addr_o), 32'd3);
    rst_i = 1'b1; #1;
    chk("mid_rst_we", 32'(char_map_we_o), 32'd0);
    chk("mid_rst_addr", 32'(char_map_addr_o), 32'd0);
    chk("mid_rst_wdata", char_map_wdata_o, 32'd0);
    chk("mid_rst_pready", 32'(pready_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    good("post_rst_wr", 14'h000C, 1'b1, 32'h1111_2222, 4'hF, 32'd0);
    good("post_rst_rd", 14'h000C, 1'b0, 32'd0, 4'hF, 32'h1111_2222);

    // Partial-strobe write to col_map word 5.
    good("col5_wr", 14'h1014, 1'b1, 32'h0A0B_0C0D, 4'b0011, 32'd0);
    chk("col5_addr", 32'(col_map_addr_o), 32'd5);
    chk("col5_be", 32'(col_map_be_o), 32'h3);
    chk("col5_char_addr_hold", 32'(char_map_addr_o), 32'd3);
    good("col5_rd", 14'h1014, 1'b0, 32'd0, 4'hF, 32'h0000_0C0D);

    // Top char_tiff word read.
    tiff_mem[1023] = 32'hDEAD_BEEF;
    good("tiff1023_rd", 14'h2FFC, 1'b0, 32'd0, 4'hF, 32'hDEAD_BEEF);

    // Last legal char_map word and an empty-strobe write.
    good("ch599_wr", 14'h095C, 1'b1, 32'h5A5A_A5A5, 4'hF, 32'd0);
    good("ch599_be0", 14'h095C, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'd0);
    chk("ch599_be0_be", 32'(char_map_be_o), 32'd0);
    good("ch599_rd", 14'h095C, 1'b0, 32'd0, 4'hF, 32'h5A5A_A5A5);

    bad("err_ch600", 14'h0960, 1'b0, 4'hF);
    bad("err_resv", 14'h3000, 1'b0, 4'hF);
    bad("err_unalign", 14'h0002, 1'b0, 4'hF);
    bad("err_tiff_strb", 14'h2000, 1'b1, 4'b0111);
    bad("err_col600_wr", 14'h1960, 1'b1, 4'hF);

    // Abort: psel drops during ACCESS of a read; no pready may follow.
    @(posedge clk_i); #1;
    paddr_i = 14'h0004; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk($sformatf("abort_pready_%0d", i), 32'(pready_o), 32'd0);
    end
    good("after_abort_rd", 14'h000C, 1'b0, 32'd0, 4'hF, 32'h1111_2222);

    // Full sweep: col_map, char_map, char_tiff writes, then read everything back.
    for (int i = 0; i < 600; i++) good($sformatf("sw_col_wr%0d", i), 14'h1000 | 14'(i * 4), 1'b1, sweep_val(1, i), 4'hF, 32'd0);
    for (int i = 0; i < 600; i++) good($sformatf("sw_ch_wr%0d", i), 14'(i * 4), 1'b1, sweep_val(0, i), 4'hF, 32'd0);
    for (int i = 0; i < 1024; i++) good($sformatf("sw_tf_wr%0d", i), 14'h2000 | 14'(i * 4), 1'b1, sweep_val(2, i), 4'hF, 32'd0);
    for (int i = 0; i < 600; i++) good($sformatf("sw_col_rd%0d", i), 14'h1000 | 14'(i * 4), 1'b0, 32'd0, 4'hF, sweep_val(1, i));
    for (int i = 0; i < 600; i++) good($sformatf("sw_ch_rd%0d", i), 14'(i * 4), 1'b0, 32'd0, 4'hF, sweep_val(0, i));
    for (int i = 0; i < 1024; i++) good($sformatf("sw_tf_rd%0d", i), 14'h2000 | 14'(i * 4), 1'b0, 32'd0, 4'hF, sweep_val(2, i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_vgachargen_ctrl.md
Name: apb_vgachargen_ctrl

Overview:
APB3 slave front-end that sits directly upstream of vgachargen and shares its clk_i.
- Decodes each APB transfer onto one of vgachargen's three memory ports: char_map, col_map and char_tiff.
- Issues one write strobe or one synchronous read per transfer and returns read data one cycle later.
- Signals errors for out-of-range or illegal accesses.

Parameters:
APB_ADDR_W, 14, width of paddr_i (byte address; three 4 KiB windows plus a reserved window)
CH_MAP_WORDS, 600, legal words in char_map (0..599)
COL_MAP_WORDS, 600, legal words in col_map (0..599)
TIFF_WORDS, 1024, legal words in char_tiff (0..1023)

Ports:
clk_i  in  1  system clock (APB PCLK)
rst_i  in  1  asynchronous reset, active-high
paddr_i  in  APB_ADDR_W  APB byte address
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  1 = write
pwdata_i  in  32  write data
pstrb_i  in  4  byte strobes
prdata_o  out  32  read data
pready_o  out  1  transfer complete
pslverr_o  out  1  error response
char_map_addr_o  out  10  word address
char_map_we_o  out  1  write strobe
char_map_be_o  out  4  byte enables
char_map_wdata_o  out  32  write data
char_map_rdata_i  in  32  read data, 1-cycle synchronous
col_map_addr_o  out  10  word address
col_map_we_o  out  1  write strobe
col_map_be_o  out  4  byte enables
col_map_wdata_o  out  32  write data
col_map_rdata_i  in  32  read data, 1-cycle synchronous
char_tiff_addr_o  out  10  word address
char_tiff_we_o  out  1  write strobe
char_tiff_wdata_o  out  32  write data
char_tiff_rdata_i  in  32  read data, 1-cycle synchronous

Behaviour:
- Address map, decoded on paddr_i[13:12]:
  - 0 = char_map
  - 1 = col_map
  - 2 = char_tiff
  - 3 = reserved, always errors
- Word index is paddr_i[11:2].
- Reset values: all outputs 0; FSM state IDLE; capture registers 0. Reset asserted mid-transfer forces IDLE immediately and drops every *_we_o asynchronously.
- FSM, three states:
  - IDLE: on psel_i & ~penable_i (setup phase), capture paddr, pwrite, pwdata, pstrb and the decoded error flag, then go to ACCESS. Any other input stays IDLE with pready_o = 0.
  - ACCESS, error case: pready_o = 1, pslverr_o = 1, prdata_o = 0, no memory strobe, go to IDLE.
  - ACCESS, normal case: the selected *_addr_o is already driven from the capture register. For a write, *_we_o = 1 for exactly this cycle. For a read, no strobe is needed. pready_o = 0; go to RESP.
  - RESP: pready_o = 1 and pslverr_o = 0. For a read, prdata_o = rdata of the captured target; for a write, prdata_o = 0. Go to IDLE.
- psel_i low while in ACCESS or RESP is an abort: go to IDLE with no further strobe.
- Latency: a good transfer is setup + 2 access cycles (1 wait state). An error is setup + 1 access cycle.
- Error conditions (checked at setup):
  - word index >= the window's *_WORDS;
  - reserved window;
  - paddr_i[1:0] != 0;
  - char_tiff write with pstrb_i != 4'hF (char_tiff has no byte enables).
  - A write with pstrb_i = 0 to char_map or col_map is legal: we pulses with be = 0.
- Address, be and wdata outputs hold their last captured value between transfers. Only the selected window's outputs update; the other windows' outputs hold unchanged.
- At most one *_we_o is high in any cycle.
- Back-to-back transfers: a setup phase in the same cycle the FSM returns to IDLE is accepted on the next edge, so a new setup is seen only in IDLE.

Decomposition:
- vgachargen_pkg gains:
  - window constants WIN_CH_MAP = 2'd0, WIN_COL_MAP = 2'd1, WIN_TIFF = 2'd2;
  - typedef apb_state_e {IDLE, ACCESS, RESP};
  - MEM_ADDR_W = 10 and MEM_DATA_W = 32.
- Single module, no sub-module; the decoder is a function in the package.

Test Plan:
- Reset: assert rst_i mid-ACCESS of a char_map write -> we drops the same cycle; all outputs 0; next transfer completes normally.
- Write col_map word 5 = 32'h0A0B0C0D with pstrb 4'b0011 -> one cycle with col_map_we_o = 1, addr = 5, be = 4'b0011; pready high on the 2nd access cycle; pslverr = 0.
- Read char_tiff word 1023 (paddr 14'h2FFC) with the memory model returning 32'hDEADBEEF -> prdata_o = 32'hDEADBEEF on the pready cycle; no we.
- Errors, each giving pready + pslverr on the 1st access cycle and no *_we_o:
  - char_map word 600 (paddr 14'h0960);
  - paddr 14'h3000;
  - paddr 14'h0002;
  - char_tiff write with pstrb 4'b0111.
- Sweep all 600 col_map words, then 600 char_map words, then 1024 char_tiff words, writing counter values and reading back through memory models -> every read matches; exactly one we per write.
- Abort: drop psel_i during ACCESS of a read -> FSM IDLE next cycle; pready never asserted for that transfer.
